// File: rtl/riscv_next_pc_gen.sv
// Next-PC generator: holds the fetch PC, arbitrates EX/ID redirects,
// parks a redirect while fetch is stalled, and pulses a fetch flush
// once per applied redirect.
module riscv_next_pc_gen #(
    parameter int unsigned             ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  i_inject,
    input  logic [ADDR_WIDTH-1:0] i_inject_addr,
    input  logic                  i_ex_redirect,
    input  logic [ADDR_WIDTH-1:0] i_ex_redirect_addr,
    input  logic                  i_fetch_ready,
    output logic                  o_fetch_valid,
    output logic [ADDR_WIDTH-1:0] o_fetch_pc,
    output logic                  o_fetch_flush,
    output logic [31:0]           o_redirect_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    // Source tag for the parked redirect; EX outranks ID.
    localparam logic SRC_ID = 1'b0;
    localparam logic SRC_EX = 1'b1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic                    pend_src_q, pend_src_d;
    logic                    flush_q, flush_d;
    logic [31:0]             count_q, count_d;

    logic                    handshake;
    logic [ADDR_WIDTH-1:0]   ex_tgt, id_tgt, pc_seq;

    // Targets are halfword-aligned at minimum; bit 0 is always dropped.
    assign ex_tgt = {i_ex_redirect_addr[ADDR_WIDTH-1:1], 1'b0};
    assign id_tgt = {i_inject_addr[ADDR_WIDTH-1:1], 1'b0};
    assign pc_seq = pc_q + ADDR_WIDTH'(4);

    assign o_fetch_valid    = (state_q != BOOT);
    assign o_fetch_pc       = pc_q;
    assign o_fetch_flush    = flush_q;
    assign o_redirect_count = count_q;

    assign handshake = o_fetch_valid && i_fetch_ready && enable;

    // Next-state, PC, pending-redirect and flush/counter decisions.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        pend_src_d  = pend_src_q;
        flush_d     = 1'b0;
        count_d     = count_q;

        unique case (state_q)
            BOOT: begin
                // Redirects seen here have nothing to redirect; ignore them.
                state_d = RUN;
            end

            RUN: begin
                if (i_ex_redirect || i_inject) begin
                    if (handshake) begin
                        pc_d    = i_ex_redirect ? ex_tgt : id_tgt;
                        flush_d = 1'b1;
                        count_d = (count_q == '1) ? count_q : count_q + 32'd1;
                    end else begin
                        // PC must stay stable while the request is unaccepted.
                        pend_addr_d = i_ex_redirect ? ex_tgt : id_tgt;
                        pend_src_d  = i_ex_redirect ? SRC_EX : SRC_ID;
                        state_d     = PEND;
                    end
                end else if (handshake) begin
                    pc_d = pc_seq;
                end
            end

            PEND: begin
                // EX always replaces; ID only replaces an older ID target.
                if (i_ex_redirect) begin
                    pend_addr_d = ex_tgt;
                    pend_src_d  = SRC_EX;
                end else if (i_inject && pend_src_q == SRC_ID) begin
                    pend_addr_d = id_tgt;
                    pend_src_d  = SRC_ID;
                end
                if (handshake) begin
                    pc_d    = pend_addr_d;
                    state_d = RUN;
                    flush_d = 1'b1;
                    count_d = (count_q == '1) ? count_q : count_q + 32'd1;
                end
            end

            default: state_d = BOOT;
        endcase
    end

    // State register; reset wins over everything, enable=0 freezes all.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            pend_addr_q <= '0;
            pend_src_q  <= SRC_ID;
            flush_q     <= 1'b0;
            count_q     <= '0;
        end else if (enable) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            pend_src_q  <= pend_src_d;
            flush_q     <= flush_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_riscv_next_pc_gen.sv
// Directed testbench for riscv_next_pc_gen (ADDR_WIDTH=64, RESET_PC=0).
module tb_riscv_next_pc_gen;

    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          i_inject;
    logic [AW-1:0] i_inject_addr;
    logic          i_ex_redirect;
    logic [AW-1:0] i_ex_redirect_addr;
    logic          i_fetch_ready;
    logic          o_fetch_valid;
    logic [AW-1:0] o_fetch_pc;
    logic          o_fetch_flush;
    logic [31:0]   o_redirect_count;

    int errors = 0;
    int checks = 0;

    riscv_next_pc_gen #(.ADDR_WIDTH(AW), .RESET_PC('0)) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .i_inject           (i_inject),
        .i_inject_addr      (i_inject_addr),
        .i_ex_redirect      (i_ex_redirect),
        .i_ex_redirect_addr (i_ex_redirect_addr),
        .i_fetch_ready      (i_fetch_ready),
        .o_fetch_valid      (o_fetch_valid),
        .o_fetch_pc         (o_fetch_pc),
        .o_fetch_flush      (o_fetch_flush),
        .o_redirect_count   (o_redirect_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_inject = 0; i_inject_addr = '0;
        i_ex_redirect = 0; i_ex_redirect_addr = '0;
    endtask

    task automatic test_reset();
        reset = 1; enable = 1; i_fetch_ready = 1; idle_inputs();
        tick(); tick();
        checks++; if (o_fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", o_fetch_valid); end
        checks++; if (o_fetch_pc !== 64'h0) begin errors++; $display("FAIL rst_pc got=%0h exp=0", o_fetch_pc); end
        checks++; if (o_fetch_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got=%0b exp=0", o_fetch_flush); end
        checks++; if (o_redirect_count !== 32'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", o_redirect_count); end
    endtask

    // Redirects in BOOT are ignored; valid rises, PC still RESET_PC.
    task automatic test_boot_ignore();
        reset = 0;
        i_ex_redirect = 1; i_ex_redirect_addr = 64'h800;
        tick();
        idle_inputs();
        checks++; if (o_fetch_valid !== 1'b1) begin errors++; $display("FAIL boot_valid got=%0b exp=1", o_fetch_valid); end
        checks++; if (o_fetch_pc !== 64'h0) begin errors++; $display("FAIL boot_pc got=%0h exp=0", o_fetch_pc); end
        checks++; if (o_redirect_count !== 32'd0) begin errors++; $display("FAIL boot_count got=%0d exp=0", o_redirect_count); end
    endtask

    task automatic test_sequential();
        logic [AW-1:0] exp_pc [4];
        exp_pc[0] = 64'h4; exp_pc[1] = 64'h8; exp_pc[2] = 64'hC; exp_pc[3] = 64'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (o_fetch_pc !== exp_pc[i] || o_fetch_flush !== 1'b0)
                begin errors++; $display("FAIL seq_pc[%0d] got=%0h/%0b exp=%0h/0", i, o_fetch_pc, o_fetch_flush, exp_pc[i]); end
        end
    endtask

    task automatic test_inject();
        i_ex_redirect = 1; i_ex_redirect_addr = 64'h100;
        tick(); idle_inputs();
        checks++; if (o_fetch_pc !== 64'h100 || o_redirect_count !== 32'd1)
            begin errors++; $display("FAIL setup_100 got=%0h/%0d exp=100/1", o_fetch_pc, o_redirect_count); end
        i_inject = 1; i_inject_addr = 64'h201;
        tick(); idle_inputs();
        checks++; if (o_fetch_pc !== 64'h200) begin errors++; $display("FAIL inj_pc got=%0h exp=200", o_fetch_pc); end
        checks++; if (o_fetch_flush !== 1'b1) begin errors++; $display("FAIL inj_flush got=%0b exp=1", o_fetch_flush); end
        checks++; if (o_redirect_count !== 32'd2) begin errors++; $display("FAIL inj_count got=%0d exp=2", o_redirect_count); end
        tick();
        checks++; if (o_fetch_flush !== 1'b0 || o_fetch_pc !== 64'h204)
            begin errors++; $display("FAIL inj_after got=%0h/%0b exp=204/0", o_fetch_pc, o_fetch_flush); end
    endtask

    task automatic test_priority();
        i_ex_redirect = 1; i_ex_redirect_addr = 64'h400;
        i_inject = 1; i_inject_addr = 64'h800;
        tick(); idle_inputs();
        checks++; if (o_fetch_pc !== 64'h400 || o_redirect_count !== 32'd3)
            begin errors++; $display("FAIL prio got=%0h/%0d exp=400/3", o_fetch_pc, o_redirect_count); end
    endtask

    task automatic test_stall_pend();
        i_ex_redirect = 1; i_ex_redirect_addr = 64'h100;
        tick(); idle_inputs();                                   // count 4, pc 100
        i_fetch_ready = 0; i_inject = 1; i_inject_addr = 64'h300;
        tick(); idle_inputs();
        checks++; if (o_fetch_pc !== 64'h100 || o_fetch_flush !== 1'b0 || o_redirect_count !== 32'd4)
            begin errors++; $display("FAIL pend1 got=%0h/%0b/%0d exp=100/0/4", o_fetch_pc, o_fetch_flush, o_redirect_count); end
        i_ex_redirect = 1; i_ex_redirect_addr = 64'h500;
        tick(); idle_inputs();
        checks++; if (o_fetch_pc !== 64'h100 || o_fetch_flush !== 1'b0)
            begin errors++; $display("FAIL pend2 got=%0h/%0b exp=100/0", o_fetch_pc, o_fetch_flush); end
        i_fetch_ready = 1;
        tick();
        checks++; if (o_fetch_pc !== 64'h500 || o_fetch_flush !== 1'b1 || o_redirect_count !== 32'd5)
            begin errors++; $display("FAIL pend_rel got=%0h/%0b/%0d exp=500/1/5", o_fetch_pc, o_fetch_flush, o_redirect_count); end
        tick();
        checks++; if (o_fetch_pc !== 64'h504 || o_fetch_flush !== 1'b0 || o_redirect_count !== 32'd5)
            begin errors++; $display("FAIL pend_after got=%0h/%0b/%0d exp=504/0/5", o_fetch_pc, o_fetch_flush, o_redirect_count); end
    endtask

    // Pending EX target is not displaced by a later inject.
    task automatic test_pend_ex_keeps();
        i_fetch_ready = 0; i_ex_redirect = 1; i_ex_redirect_addr = 64'h600;
        tick(); idle_inputs();
        i_inject = 1; i_inject_addr = 64'h700;
        tick(); idle_inputs();
        i_fetch_ready = 1;
        tick();
        checks++; if (o_fetch_pc !== 64'h600 || o_redirect_count !== 32'd6)
            begin errors++; $display("FAIL pend_ex got=%0h/%0d exp=600/6", o_fetch_pc, o_redirect_count); end
    endtask

    // Pending ID target is replaced by a newer inject on the handshake cycle.
    task automatic test_pend_id_replace();
        i_fetch_ready = 0; i_inject = 1; i_inject_addr = 64'h900;
        tick(); idle_inputs();
        tick();
        i_fetch_ready = 1; i_inject = 1; i_inject_addr = 64'hA01;
        tick(); idle_inputs();
        checks++; if (o_fetch_pc !== 64'hA00 || o_redirect_count !== 32'd7 || o_fetch_flush !== 1'b1)
            begin errors++; $display("FAIL pend_id got=%0h/%0d/%0b exp=a00/7/1", o_fetch_pc, o_redirect_count, o_fetch_flush); end
    endtask

    task automatic test_enable();
        i_ex_redirect = 1; i_ex_redirect_addr = 64'hC00;
        tick();                                                  // flush=1, count 8
        enable = 0; i_ex_redirect_addr = 64'hD00;
        tick(); tick();
        checks++; if (o_fetch_pc !== 64'hC00 || o_fetch_flush !== 1'b1 || o_redirect_count !== 32'd8)
            begin errors++; $display("FAIL en_hold got=%0h/%0b/%0d exp=c00/1/8", o_fetch_pc, o_fetch_flush, o_redirect_count); end
        enable = 1; idle_inputs();
        tick();
        checks++; if (o_fetch_pc !== 64'hC04 || o_fetch_flush !== 1'b0)
            begin errors++; $display("FAIL en_resume got=%0h/%0b exp=c04/0", o_fetch_pc, o_fetch_flush); end
    endtask

    task automatic test_wrap();
        i_ex_redirect = 1; i_ex_redirect_addr = 64'hFFFF_FFFF_FFFF_FFFD;
        tick(); idle_inputs();
        checks++; if (o_fetch_pc !== 64'hFFFF_FFFF_FFFF_FFFC)
            begin errors++; $display("FAIL wrap_tgt got=%0h exp=fffffffffffffffc", o_fetch_pc); end
        tick();
        checks++; if (o_fetch_pc !== 64'h0) begin errors++; $display("FAIL wrap_pc got=%0h exp=0", o_fetch_pc); end
    endtask

    task automatic test_reset_in_pend();
        i_fetch_ready = 0; i_ex_redirect = 1; i_ex_redirect_addr = 64'h300;
        tick(); idle_inputs();
        reset = 1;
        tick();
        checks++; if (o_fetch_valid !== 1'b0 || o_fetch_pc !== 64'h0 || o_redirect_count !== 32'd0 || o_fetch_flush !== 1'b0)
            begin errors++; $display("FAIL rstpend got=%0b/%0h/%0d/%0b exp=0/0/0/0", o_fetch_valid, o_fetch_pc, o_redirect_count, o_fetch_flush); end
        reset = 0; i_fetch_ready = 1;
        tick();
        tick();
        checks++; if (o_fetch_pc !== 64'h4 || o_redirect_count !== 32'd0 || o_fetch_flush !== 1'b0)
            begin errors++; $display("FAIL rstpend_lost got=%0h/%0d/%0b exp=4/0/0", o_fetch_pc, o_redirect_count, o_fetch_flush); end
    endtask

    initial begin
        test_reset();
        test_boot_ignore();
        test_sequential();
        test_inject();
        test_priority();
        test_stall_pend();
        test_pend_ex_keeps();
        test_pend_id_replace();
        test_enable();
        test_wrap();
        test_reset_in_pend();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_next_pc_gen.md
RISCV_NEXT_PC_GEN -- requirements
Module: riscv_next_pc_gen

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, width of every address port and of the PC register.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-005 enable  in  1  global advance; 0 freezes all state.
REQ-006 i_inject  in  1  jump-predictor redirect request from ID, already gated by the ID flush.
REQ-007 i_inject_addr  in  ADDR_WIDTH  jump-predictor target.
REQ-008 i_ex_redirect  in  1  branch-resolution or mispredict redirect from EX.
REQ-009 i_ex_redirect_addr  in  ADDR_WIDTH  EX target.
REQ-010 i_fetch_ready  in  1  fetch unit accepts o_fetch_pc this cycle.
REQ-011 o_fetch_valid  out  1  o_fetch_pc is a valid request.
REQ-012 o_fetch_pc  out  ADDR_WIDTH  fetch address (PC register).
REQ-013 o_fetch_flush  out  1  one-cycle pulse: discard all in-flight fetch/ID instructions.
REQ-014 o_redirect_count  out  32  saturating count of applied redirects.

Function
REQ-015 FSM states: BOOT, RUN, PEND; state, PC, pending target/source, flush and counter are registers.
REQ-016 A handshake occurs when o_fetch_valid && i_fetch_ready && enable.
REQ-017 BOOT: o_fetch_valid=0, o_fetch_pc=RESET_PC; BOOT->RUN on the first enabled cycle after reset; redirects arriving in BOOT are ignored.
REQ-018 RUN/PEND: o_fetch_valid=1.
REQ-019 Priority: i_ex_redirect over i_inject; a simultaneous i_inject is dropped and not counted.
REQ-020 Every target is used with bit 0 cleared.
REQ-021 Sequential PC update is PC+4, modulo 2^ADDR_WIDTH, wrapping without error.
REQ-022 RUN, handshake, no redirect: PC<=PC+4.
REQ-023 RUN, redirect, handshake: PC<=target, stay RUN, o_fetch_flush=1 next cycle, counter+1.
REQ-024 RUN, redirect, no handshake: PC held, because the payload stays stable while valid and not accepted.
REQ-025 In the REQ-024 case, target and source (EX/ID) are stored in the pending register and the state moves to PEND.
REQ-026 PEND, no handshake: new i_ex_redirect overwrites the pending target/source.
REQ-027 PEND, no handshake: new i_inject overwrites only a pending ID-sourced target and is otherwise dropped.
REQ-028 PEND, handshake: PC<=newest winning target; the same-cycle winner uses REQ-026/027 rules.
REQ-029 PEND, handshake (cont.): state->RUN, o_fetch_flush=1 next cycle, counter+1 once only.
REQ-030 o_fetch_flush is registered, high exactly one cycle per applied redirect, otherwise 0.
REQ-031 enable=0: no register changes, no handshake counted; outputs hold their values except that o_fetch_flush holds its value.
REQ-032 o_redirect_count saturates at 0xFFFF_FFFF.
REQ-033 Latency: redirect-to-o_fetch_pc is 1 cycle when i_fetch_ready=1, otherwise 1 cycle after the stalled handshake.

Reset
REQ-034 On reset=1 at a clock edge: state=BOOT, PC=RESET_PC, pending cleared, o_fetch_flush=0, o_redirect_count=0, o_fetch_valid=0.
REQ-035 Reset has priority over enable and all requests, including mid-PEND; the pending target is lost.

Verification
REQ-036 Reset, then ready=1 for 4 cycles -> valid from cycle 2; fetch_pc 0,4,8,12; flush=0.
REQ-037 PC=0x100, i_inject=1, addr 0x201, ready=1 -> next fetch_pc=0x200, flush pulse 1 cycle, count=1.
REQ-038 Same cycle i_ex_redirect 0x400 and i_inject 0x800 -> fetch_pc=0x400, count=1.
REQ-039 PC=0x100, ready=0: inject 0x300 ...
REQ-040 ... then ex 0x500 while still stalled, then ready=1 -> 0x100 held until the handshake, then 0x500, single flush, count=1.
REQ-041 PC=2^ADDR_WIDTH-4, handshake -> PC=0.
REQ-042 reset asserted in PEND -> next cycle BOOT, PC=RESET_PC, pending discarded.
